// File: rtl/usb_host_xact.sv
// rtl/usb_host_xact.sv - USB full-speed host transaction initiator (SETUP/OUT/IN with handshake)
// Ports:
//   cmd_*              command request (type, addr, endp, toggle, len), accepted while cmd_ready
//   out_data/valid/ready  OUT/SETUP payload bytes from the caller
//   in_data/in_valid   received IN payload bytes, one-cycle strobes
//   res_valid/code/len one-cycle transaction result
//   tx_*               packet-layer transmit side (PID + byte stream, CRC16 added downstream)
//   rx_*               packet-layer receive side (PID + byte stream, CRC16 checked upstream)
module usb_host_xact #(
  parameter int TIMEOUT_CYCLES = 80,
  parameter int TURN_CYCLES    = 8,
  parameter int MAX_PKT        = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [6:0] cmd_addr,
  input  logic [3:0] cmd_endp,
  input  logic       cmd_toggle,
  input  logic [6:0] cmd_len,
  input  logic [7:0] out_data,
  input  logic       out_valid,
  output logic       out_ready,
  output logic [7:0] in_data,
  output logic       in_valid,
  output logic       res_valid,
  output logic [2:0] res_code,
  output logic [6:0] res_len,
  output logic [3:0] tx_pid,
  output logic [7:0] tx_data,
  output logic       tx_data_valid,
  output logic       tx_pkt_start,
  output logic       tx_pkt_end,
  input  logic       tx_ready,
  input  logic [3:0] rx_pid,
  input  logic       rx_pid_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  input  logic       rx_pkt_start,
  input  logic       rx_pkt_end,
  input  logic       rx_crc_err
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam logic [2:0] RC_ACK = 3'd0, RC_NAK = 3'd1, RC_STALL = 3'd2, RC_TIMEOUT = 3'd3;
  localparam logic [2:0] RC_CRC = 3'd4, RC_TOGGLE = 3'd5, RC_BABBLE = 3'd6, RC_PROTO = 3'd7;

  localparam logic [6:0]  MAX_LEN  = 7'(MAX_PKT);
  localparam logic [15:0] TO_LIM   = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] TURN_LIM = 16'(TURN_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, TOK_START, TOK_B0, TOK_B1, TOK_END, DAT_START, DAT_BYTES, DAT_END,
    WAIT_RESP, RX_PKT, TURN, ACK_START, ACK_END, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  addr_q, addr_d;
  logic [3:0]  endp_q, endp_d;
  logic        toggle_q, toggle_d;
  logic        is_in_q, is_in_d;
  logic        is_setup_q, is_setup_d;
  logic [6:0]  len_q, len_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [15:0] timer_q, timer_d;
  logic        babble_q, babble_d;
  logic [2:0]  code_q, code_d;
  logic [3:0]  rpid_q, rpid_d;
  logic [7:0]  txd_q, txd_d;
  logic        txv_q, txv_d;
  logic [7:0]  ind_q, ind_d;
  logic        inv_q, inv_d;

  // Remainder is sent MSB first on the wire, while the token byte is sent
  // LSB first, so the inverted remainder is bit-reversed into the field.
  function automatic logic [4:0] crc5_field(input logic [10:0] bits);
    logic [4:0] c;
    c = 5'h1f;
    for (int i = 0; i < 11; i++) begin
      if (c[4] ^ bits[i]) c = {c[3:0], 1'b0} ^ 5'b00101;
      else                c = {c[3:0], 1'b0};
    end
    return {~c[0], ~c[1], ~c[2], ~c[3], ~c[4]};
  endfunction

  logic [3:0] tok_pid, dat_pid, pid_now;
  logic [7:0] tok_b0, tok_b1;
  logic       data_pid;

  assign tok_pid  = is_in_q ? PID_IN : (is_setup_q ? PID_SETUP : PID_OUT);
  assign dat_pid  = (toggle_q && !is_setup_q) ? PID_DATA1 : PID_DATA0;
  assign tok_b0   = {endp_q[0], addr_q};
  assign tok_b1   = {crc5_field({endp_q, addr_q}), endp_q[3:1]};
  // PID may arrive in the same cycle as the first data byte or the end
  assign pid_now  = rx_pid_valid ? rx_pid : rpid_q;
  assign data_pid = is_in_q && (pid_now == PID_DATA0 || pid_now == PID_DATA1);

  assign in_data  = ind_q;
  assign in_valid = inv_q;

  always_comb begin
    state_d = state_q;  addr_d = addr_q;   endp_d = endp_q;     toggle_d = toggle_q;
    is_in_d = is_in_q;  is_setup_d = is_setup_q; len_d = len_q; cnt_d = cnt_q;
    timer_d = timer_q;  babble_d = babble_q; code_d = code_q;   rpid_d = rpid_q;
    txd_d = txd_q;      txv_d = txv_q;     ind_d = ind_q;       inv_d = 1'b0;
    cmd_ready = 1'b0;   out_ready = 1'b0;  res_valid = 1'b0;    res_code = 3'd0;
    res_len = 7'd0;     tx_pid = 4'd0;     tx_data = 8'd0;      tx_data_valid = 1'b0;
    tx_pkt_start = 1'b0; tx_pkt_end = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d     = cmd_addr;
          endp_d     = cmd_endp;
          toggle_d   = cmd_toggle;
          is_in_d    = cmd_type[1];
          is_setup_d = (cmd_type == 2'd0);
          len_d      = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
          cnt_d      = 7'd0;
          babble_d   = 1'b0;
          code_d     = RC_ACK;
          rpid_d     = 4'd0;
          txv_d      = 1'b0;
          state_d    = TOK_START;
        end
      end
      TOK_START: begin
        tx_pkt_start = 1'b1;
        tx_pid       = tok_pid;
        state_d      = TOK_B0;
      end
      TOK_B0: begin
        tx_pid = tok_pid; tx_data = tok_b0; tx_data_valid = 1'b1;
        if (tx_ready) state_d = TOK_B1;
      end
      TOK_B1: begin
        tx_pid = tok_pid; tx_data = tok_b1; tx_data_valid = 1'b1;
        if (tx_ready) state_d = TOK_END;
      end
      TOK_END: begin
        tx_pid = tok_pid;
        if (tx_ready) begin
          tx_pkt_end = 1'b1;
          timer_d    = 16'd1;
          state_d    = is_in_q ? WAIT_RESP : DAT_START;
        end
      end
      DAT_START: begin
        tx_pkt_start = 1'b1;
        tx_pid       = dat_pid;
        state_d      = DAT_BYTES;
      end
      DAT_BYTES: begin
        tx_pid = dat_pid; tx_data = txd_q; tx_data_valid = txv_q;
        if (txv_q && tx_ready) txv_d = 1'b0;
        // Reload the holding byte in the same cycle the previous one drains
        if (cnt_q != len_q && out_valid && (!txv_q || tx_ready)) begin
          out_ready = 1'b1;
          txd_d     = out_data;
          txv_d     = 1'b1;
          cnt_d     = cnt_q + 7'd1;
        end else if (cnt_q == len_q && !txv_q) begin
          state_d = DAT_END;
        end
      end
      DAT_END: begin
        tx_pid = dat_pid;
        if (tx_ready) begin
          tx_pkt_end = 1'b1;
          timer_d    = 16'd1;
          state_d    = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (rx_pid_valid) rpid_d = rx_pid;
        if (rx_pkt_start) begin
          state_d = RX_PKT;
        end else if (timer_q == TO_LIM) begin
          code_d  = RC_TIMEOUT;
          state_d = DONE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      RX_PKT: begin
        if (rx_pid_valid) rpid_d = rx_pid;
        if (rx_data_valid && data_pid) begin
          if (cnt_q != len_q) begin
            ind_d = rx_data;
            inv_d = 1'b1;
            cnt_d = cnt_q + 7'd1;
          end else begin
            babble_d = 1'b1;
          end
        end
        if (rx_pkt_end) begin
          state_d = DONE;
          if (data_pid) begin
            if (rx_crc_err) begin
              code_d = RC_CRC;
            end else begin
              state_d = TURN;
              timer_d = 16'd0;
              if (babble_d)                    code_d = RC_BABBLE;
              else if (pid_now[3] != toggle_q) code_d = RC_TOGGLE;
              else                             code_d = RC_ACK;
            end
          end else if (rx_crc_err)                  code_d = RC_PROTO;
          else if (pid_now == PID_ACK && !is_in_q)  code_d = RC_ACK;
          else if (pid_now == PID_NAK)              code_d = RC_NAK;
          else if (pid_now == PID_STALL)            code_d = RC_STALL;
          else                                      code_d = RC_PROTO;
        end
      end
      TURN: begin
        if (timer_q == TURN_LIM) state_d = ACK_START;
        else                     timer_d = timer_q + 16'd1;
      end
      ACK_START: begin
        tx_pkt_start = 1'b1;
        tx_pid       = PID_ACK;
        state_d      = ACK_END;
      end
      ACK_END: begin
        tx_pid = PID_ACK;
        if (tx_ready) begin
          tx_pkt_end = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        res_code  = code_q;
        res_len   = cnt_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;  addr_q <= 7'd0;  endp_q <= 4'd0;   toggle_q <= 1'b0;
      is_in_q <= 1'b0;  is_setup_q <= 1'b0; len_q <= 7'd0; cnt_q <= 7'd0;
      timer_q <= 16'd0; babble_q <= 1'b0; code_q <= 3'd0;  rpid_q <= 4'd0;
      txd_q <= 8'd0;    txv_q <= 1'b0;   ind_q <= 8'd0;    inv_q <= 1'b0;
    end else begin
      state_q <= state_d; addr_q <= addr_d; endp_q <= endp_d; toggle_q <= toggle_d;
      is_in_q <= is_in_d; is_setup_q <= is_setup_d; len_q <= len_d; cnt_q <= cnt_d;
      timer_q <= timer_d; babble_q <= babble_d; code_q <= code_d; rpid_q <= rpid_d;
      txd_q <= txd_d;     txv_q <= txv_d;   ind_q <= ind_d;   inv_q <= inv_d;
    end
  end

endmodule

// File: tb/tb_usb_host_xact.sv
// tb/tb_usb_host_xact.sv - directed self-checking bench for usb_host_xact
module tb_usb_host_xact;
  localparam int TO = 80;
  localparam int TC = 8;
  localparam logic [36:0] RESET_VEC = {1'b1, 36'd0};

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_toggle;
  logic [1:0] cmd_type;
  logic [6:0] cmd_addr, cmd_len;
  logic [3:0] cmd_endp;
  logic [7:0] out_data = 8'd0;
  logic       out_valid, out_ready;
  logic [7:0] in_data;
  logic       in_valid, res_valid;
  logic [2:0] res_code;
  logic [6:0] res_len;
  logic [3:0] tx_pid;
  logic [7:0] tx_data;
  logic       tx_data_valid, tx_pkt_start, tx_pkt_end;
  logic       tx_ready = 1'b1;
  logic [3:0] rx_pid;
  logic       rx_pid_valid, rx_data_valid, rx_pkt_start, rx_pkt_end, rx_crc_err;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  usb_host_xact #(.TIMEOUT_CYCLES(TO), .TURN_CYCLES(TC), .MAX_PKT(64)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_endp(cmd_endp), .cmd_toggle(cmd_toggle), .cmd_len(cmd_len),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .in_data(in_data),
    .in_valid(in_valid), .res_valid(res_valid), .res_code(res_code), .res_len(res_len),
    .tx_pid(tx_pid), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
    .tx_pkt_start(tx_pkt_start), .tx_pkt_end(tx_pkt_end), .tx_ready(tx_ready),
    .rx_pid(rx_pid), .rx_pid_valid(rx_pid_valid), .rx_data(rx_data),
    .rx_data_valid(rx_data_valid), .rx_pkt_start(rx_pkt_start), .rx_pkt_end(rx_pkt_end),
    .rx_crc_err(rx_crc_err)
  );

  logic [36:0] outs_vec;
  assign outs_vec = {cmd_ready, out_ready, in_data, in_valid, res_valid, res_code, res_len,
                     tx_pid, tx_data, tx_data_valid, tx_pkt_start, tx_pkt_end};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: records everything the DUT emits, sampled on the falling edge
  int         cyc = 0;
  logic [7:0] tx_buf [0:1023];
  logic [3:0] pid_buf [0:255];
  int         start_cyc [0:255];
  logic [7:0] in_buf [0:255];
  int tx_n = 0, pid_n = 0, end_n = 0, in_n = 0, res_n = 0;
  int last_end_cyc = 0, res_cyc = 0, acc_cyc = 0, rx_end_cyc = 0;
  logic [2:0] res_code_s = 3'd0;
  logic [6:0] res_len_s = 7'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_data_valid && tx_ready) begin tx_buf[tx_n] = tx_data; tx_n = tx_n + 1; end
    if (tx_pkt_start) begin pid_buf[pid_n] = tx_pid; start_cyc[pid_n] = cyc; pid_n = pid_n + 1; end
    if (tx_pkt_end) begin end_n = end_n + 1; last_end_cyc = cyc; end
    if (in_valid) begin in_buf[in_n] = in_data; in_n = in_n + 1; end
    if (res_valid) begin res_n = res_n + 1; res_code_s = res_code; res_len_s = res_len; res_cyc = cyc; end
    if (cmd_valid && cmd_ready) acc_cyc = cyc;
    if (rx_pkt_end) rx_end_cyc = cyc;
  end

  // Payload source and packet-layer backpressure
  logic [7:0] payload [0:15];
  int   pay_base = 0;
  int   out_n = 0;
  logic bp_en = 1'b0;
  logic take;

  always begin
    @(negedge clk);
    take = out_ready && out_valid;
    @(posedge clk);
    #1;
    if (take) out_n = out_n + 1;
    tx_ready = bp_en ? cyc[0] : 1'b1;
    out_data = payload[(out_n - pay_base) & 15];
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] t, input logic [6:0] a, input logic [3:0] e,
                          input logic tg, input logic [6:0] l);
    int k = 0;
    cmd_type = t; cmd_addr = a; cmd_endp = e; cmd_toggle = tg; cmd_len = l; cmd_valid = 1'b1;
    while (!cmd_ready && k < 50) begin tick(); k++; end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ends(input int target, input string tag);
    int k = 0;
    while (end_n < target && k < 2000) begin tick(); k++; end
    if (end_n < target) check({tag, "_tx_end_wait"}, 64'(end_n), 64'(target));
  endtask

  task automatic wait_res(input int r0, input string tag);
    int k = 0;
    while (res_n == r0 && k < 500) begin tick(); k++; end
    if (res_n == r0) check({tag, "_res_wait"}, 64'(res_n), 64'(r0 + 1));
  endtask

  task automatic dev_resp(input logic [3:0] pid, input int nb, input logic crc);
    rx_pkt_start = 1'b1; rx_pid = pid; rx_pid_valid = 1'b1;
    tick();
    rx_pkt_start = 1'b0; rx_pid_valid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      rx_data = 8'(i + 1); rx_data_valid = 1'b1;
      tick();
    end
    rx_data_valid = 1'b0; rx_pkt_end = 1'b1; rx_crc_err = crc;
    tick();
    rx_pkt_end = 1'b0; rx_crc_err = 1'b0;
  endtask

  // SETUP to addr 0 ep 0 with a standard GET_DESCRIPTOR request; toggle 1 must be ignored
  task automatic run_setup(input string tag);
    int p0, b0, e0, r0;
    logic [63:0] got;
    payload[0] = 8'h80; payload[1] = 8'h06; payload[2] = 8'h00; payload[3] = 8'h01;
    payload[4] = 8'h00; payload[5] = 8'h00; payload[6] = 8'h12; payload[7] = 8'h00;
    pay_base = out_n;
    p0 = pid_n; b0 = tx_n; e0 = end_n; r0 = res_n;
    tick();
    send_cmd(2'd0, 7'd0, 4'd0, 1'b1, 7'd8);
    check({tag, "_cmd_ready_low"}, 64'(cmd_ready), 64'd0);
    wait_ends(e0 + 2, tag);
    check({tag, "_start_latency"}, 64'(start_cyc[p0] - acc_cyc), 64'd1);
    check({tag, "_tok_pid"}, 64'(pid_buf[p0]), 64'hD);
    check({tag, "_tok_bytes"}, {48'd0, tx_buf[b0], tx_buf[b0 + 1]}, 64'h0010);
    check({tag, "_data_pid"}, 64'(pid_buf[p0 + 1]), 64'h3);
    got = 64'd0;
    for (int i = 0; i < 8; i++) got = {got[55:0], tx_buf[b0 + 2 + i]};
    check({tag, "_data_bytes"}, got, 64'h8006000100001200);
    check({tag, "_tx_count"}, 64'(tx_n - b0), 64'd10);
    tick(2);
    dev_resp(4'b0010, 0, 1'b0);
    wait_res(r0, tag);
    check({tag, "_code"}, 64'(res_code_s), 64'd0);
    check({tag, "_len"}, 64'(res_len_s), 64'd8);
    check({tag, "_res_latency"}, 64'(res_cyc - rx_end_cyc), 64'd1);
  endtask

  task automatic run_out(input string tag, input logic tg, input logic [6:0] len,
                         input logic [3:0] rpid, input logic [2:0] exp_code, input logic [3:0] exp_dpid);
    int p0, b0, e0, r0;
    logic [63:0] got, exp;
    for (int i = 0; i < 16; i++) payload[i] = 8'(8'hA0 + i);
    pay_base = out_n;
    p0 = pid_n; b0 = tx_n; e0 = end_n; r0 = res_n;
    tick();
    send_cmd(2'd1, 7'd5, 4'd2, tg, len);
    wait_ends(e0 + 2, tag);
    check({tag, "_tok_pid"}, 64'(pid_buf[p0]), 64'h1);
    check({tag, "_data_pid"}, 64'(pid_buf[p0 + 1]), 64'(exp_dpid));
    check({tag, "_tx_count"}, 64'(tx_n - b0), 64'(2 + int'(len)));
    got = 64'd0; exp = 64'd0;
    for (int i = 0; i < int'(len); i++) begin
      got = {got[55:0], tx_buf[b0 + 2 + i]};
      exp = {exp[55:0], 8'(8'hA0 + i)};
    end
    check({tag, "_data_bytes"}, got, exp);
    tick(3);
    dev_resp(rpid, 0, 1'b0);
    wait_res(r0, tag);
    check({tag, "_code"}, 64'(res_code_s), 64'(exp_code));
    check({tag, "_len"}, 64'(res_len_s), 64'(len));
  endtask

  // IN from addr 1 ep 1; device answers with pid + nb bytes 01,02,... unless respond = 0
  task automatic run_in(input string tag, input logic tg, input logic [6:0] len, input bit respond,
                        input logic [3:0] rpid, input int nb, input logic crc,
                        input logic [2:0] exp_code, input int exp_in, input bit exp_ack);
    int p0, b0, e0, i0, r0, tok_end;
    logic [63:0] got, exp;
    p0 = pid_n; b0 = tx_n; e0 = end_n; i0 = in_n; r0 = res_n;
    send_cmd(2'd2, 7'd1, 4'd1, tg, len);
    wait_ends(e0 + 1, tag);
    tok_end = last_end_cyc;
    check({tag, "_tok"}, {44'd0, pid_buf[p0], tx_buf[b0], tx_buf[b0 + 1]}, 64'h98158);
    if (respond) begin
      tick(3);
      dev_resp(rpid, nb, crc);
    end
    wait_res(r0, tag);
    check({tag, "_code"}, 64'(res_code_s), 64'(exp_code));
    check({tag, "_len"}, 64'(res_len_s), 64'(exp_in));
    check({tag, "_in_count"}, 64'(in_n - i0), 64'(exp_in));
    got = 64'd0; exp = 64'd0;
    for (int i = 0; i < exp_in; i++) begin
      got = {got[55:0], in_buf[i0 + i]};
      exp = {exp[55:0], 8'(i + 1)};
    end
    check({tag, "_in_bytes"}, got, exp);
    check({tag, "_pkt_count"}, 64'(pid_n - p0), exp_ack ? 64'd2 : 64'd1);
    if (exp_ack) begin
      check({tag, "_ack_pid"}, 64'(pid_buf[p0 + 1]), 64'h2);
      check({tag, "_turn"}, 64'(start_cyc[p0 + 1] - rx_end_cyc), 64'(TC + 1));
      check({tag, "_res_after_ack"}, 64'(res_cyc - last_end_cyc), 64'd1);
    end else if (respond) begin
      check({tag, "_res_latency"}, 64'(res_cyc - rx_end_cyc), 64'd1);
    end else begin
      check({tag, "_timeout_latency"}, 64'(res_cyc - tok_end), 64'(TO + 1));
    end
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int p0, r0, k;
    rst = 1'b1; cmd_valid = 1'b0; cmd_type = 2'd0; cmd_addr = 7'd0; cmd_endp = 4'd0;
    cmd_toggle = 1'b0; cmd_len = 7'd0; out_valid = 1'b1;
    rx_pid = 4'd0; rx_pid_valid = 1'b0; rx_data = 8'd0; rx_data_valid = 1'b0;
    rx_pkt_start = 1'b0; rx_pkt_end = 1'b0; rx_crc_err = 1'b0;
    for (int i = 0; i < 16; i++) payload[i] = 8'd0;
    tick(3);
    check("reset_outputs", {27'd0, outs_vec}, {27'd0, RESET_VEC});
    rst = 1'b0;
    tick(2);

    bp_en = 1'b1;
    run_setup("setup");
    bp_en = 1'b0;
    run_out("out_nak", 1'b1, 7'd3, 4'b1010, 3'd1, 4'b1011);
    run_out("out_zlp_stall", 1'b0, 7'd0, 4'b1110, 3'd2, 4'b0011);

    run_in("in_ack",     1'b0, 7'd4, 1'b1, 4'b0011, 4, 1'b0, 3'd0, 4, 1'b1);
    run_in("in_nak",     1'b0, 7'd4, 1'b1, 4'b1010, 0, 1'b0, 3'd1, 0, 1'b0);
    run_in("in_stall",   1'b0, 7'd4, 1'b1, 4'b1110, 0, 1'b0, 3'd2, 0, 1'b0);
    run_in("in_timeout", 1'b0, 7'd4, 1'b0, 4'b0000, 0, 1'b0, 3'd3, 0, 1'b0);
    run_in("in_toggle",  1'b0, 7'd4, 1'b1, 4'b1011, 4, 1'b0, 3'd5, 4, 1'b1);
    run_in("in_crc",     1'b0, 7'd4, 1'b1, 4'b0011, 4, 1'b1, 3'd4, 4, 1'b0);
    run_in("in_babble",  1'b0, 7'd2, 1'b1, 4'b0011, 3, 1'b0, 3'd6, 2, 1'b1);

    // Reset in the middle of a data packet
    for (int i = 0; i < 16; i++) payload[i] = 8'(8'h50 + i);
    pay_base = out_n;
    bp_en = 1'b1;
    p0 = pid_n; r0 = res_n;
    tick();
    send_cmd(2'd1, 7'd5, 4'd2, 1'b0, 7'd8);
    k = 0;
    while (pid_n < p0 + 2 && k < 200) begin tick(); k++; end
    tick(2);
    check("rst_pre_data_pid", 64'(tx_pid), 64'h3);
    rst = 1'b1;
    #1;
    check("rst_outputs", {27'd0, outs_vec}, {27'd0, RESET_VEC});
    tick(3);
    check("rst_no_res", 64'(res_n), 64'(r0));
    rst = 1'b0;
    bp_en = 1'b0;
    tick(2);
    run_setup("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/usb_host_xact.md
# usb_host_xact

Host-side USB full-speed transaction initiator. It is the counterpart of the device core: it issues SETUP, IN and OUT tokens, sends or receives the data packet, and handles the handshake. It sits on the same packet-layer interface as the device core (PID plus byte stream, with CRC16 appended and checked by the packet layer). It is used for host-mode bring-up and as the driver in loopback benches against the mouse device.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 80: clk cycles allowed from end of host transmit to device `rx_pkt_start`.
- TURN_CYCLES, default 8: clk cycles of bus turnaround before the host sends an ACK.
- MAX_PKT, default 64: largest data payload in bytes.

Ports:
- clk  in  1: 48 MHz clock.
- rst  in  1: asynchronous, active-high reset.
- cmd_valid  in  1: command request.
- cmd_ready  out  1: block is idle and accepts a command.
- cmd_type  in  2: 0 = SETUP, 1 = OUT, 2 = IN, 3 = reserved (treated as IN).
- cmd_addr  in  7: device address.
- cmd_endp  in  4: endpoint number.
- cmd_toggle  in  1: expected or sent DATA toggle (0 = DATA0).
- cmd_len  in  7: OUT/SETUP byte count, or IN maximum; values above MAX_PKT are clamped to MAX_PKT.
- out_data  in  8: OUT/SETUP payload byte.
- out_valid  in  1: payload byte valid.
- out_ready  out  1: payload byte consumed this cycle.
- in_data  out  8: received IN payload byte.
- in_valid  out  1: in_data valid, one-cycle strobe, no backpressure.
- res_valid  out  1: one-cycle result strobe.
- res_code  out  3: 0 ACK, 1 NAK, 2 STALL, 3 TIMEOUT, 4 CRC_ERR, 5 TOGGLE_ERR, 6 BABBLE, 7 PROTO_ERR.
- res_len  out  7: IN bytes received, or OUT bytes sent.
- tx_pid  out  4: PID of the packet being sent.
- tx_data  out  8: byte being sent.
- tx_data_valid  out  1: tx_data valid; a byte transfers when tx_data_valid and tx_ready are both high.
- tx_pkt_start  out  1: one-cycle pulse that opens a packet.
- tx_pkt_end  out  1: one-cycle pulse that closes a packet.
- tx_ready  in  1: packet layer accepts a byte or end.
- rx_pid  in  4: received PID.
- rx_pid_valid  in  1: rx_pid valid strobe.
- rx_data  in  8: received byte.
- rx_data_valid  in  1: rx_data valid strobe.
- rx_pkt_start  in  1: receive packet opened.
- rx_pkt_end  in  1: receive packet closed.
- rx_crc_err  in  1: CRC16 error, valid with rx_pkt_end.

## Operation
- States: IDLE, TOK_START, TOK_B0, TOK_B1, TOK_END, DAT_START, DAT_BYTES, DAT_END, WAIT_RESP, RX_PKT, TURN, ACK_START, ACK_END, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch all cmd_* fields and go to TOK_START.
  - rx_* events arriving in IDLE are ignored.
- Token packet:
  - PID is SETUP = 1101, OUT = 0001 or IN = 1001.
  - Byte 0 = {endp[0], addr[6:0]}; byte 1 = {crc5[4:0], endp[3:1]}.
  - CRC5: polynomial x^5+x^2+1, seed 11111, computed over the 11 bits {endp, addr} LSB first, result inverted.
  - tx_pid is held stable from tx_pkt_start until tx_pkt_end.
- SETUP/OUT:
  - After the token, send a data packet with tx_pid = DATA1 if cmd_toggle else DATA0. SETUP always uses DATA0.
  - Stream cmd_len bytes; out_ready pulses only on a cycle where a byte is loaded into tx_data. cmd_len = 0 sends a zero-length packet.
  - Then WAIT_RESP. Handshake ACK, NAK or STALL maps to the matching code. Any other PID, or rx_crc_err, gives PROTO_ERR.
- IN:
  - After the token, WAIT_RESP.
  - NAK or STALL: result, no host handshake sent.
  - DATA0/DATA1: each rx_data_valid is forwarded as in_data/in_valid one cycle later and counted.
  - A byte count above cmd_len flags BABBLE; excess bytes are not forwarded.
  - At rx_pkt_end:
    - rx_crc_err gives CRC_ERR and no ACK.
    - Otherwise TURN for TURN_CYCLES, then send a PID-only ACK.
    - The code is BABBLE if flagged, else TOGGLE_ERR on toggle mismatch (the host still ACKs), else ACK.
  - Any other PID gives PROTO_ERR with no ACK.
  - The consumer discards streamed bytes unless res_code = ACK.
- WAIT_RESP timeout:
  - The counter starts at 0 on the tx_pkt_end cycle.
  - Reaching TIMEOUT_CYCLES without rx_pkt_start gives TIMEOUT.
  - Once rx_pkt_start is seen, the block waits for rx_pkt_end without a limit.
- DONE: res_valid pulses once, then IDLE. The block never changes toggle itself; the caller owns toggles.

## Timing
- Reset values: cmd_ready = 1; all other outputs 0.
- Assertion of rst immediately forces IDLE. Any transaction in progress is dropped without a res_valid.
- cmd_ready falls on the cycle after acceptance.
- tx_pkt_start is issued in the cycle after acceptance.
- Every tx_pkt_end is issued only while tx_ready = 1 and no byte is pending.
- res_valid arrives 1 cycle after the terminating event (rx_pkt_end, the ACK's tx_pkt_end, or the timeout count). A new cmd_valid can be accepted in the following cycle.
- rx_pkt_start and timeout expiry in the same cycle: rx_pkt_start wins.

## Test plan
- SETUP to addr 0, ep 0, 8 bytes 80 06 00 01 00 00 12 00, device ACKs -> token bytes 0x00 0x10; data PID DATA0 carrying the 8 bytes in order; res_code = 0, res_len = 8.
- IN to addr 1, ep 1, toggle 0, cmd_len 4; device returns DATA0 01 02 03 04 -> token bytes 0x81 0x58; 4 in_valid strobes; ACK sent after TURN_CYCLES; res_code = 0, res_len = 4.
- IN with device NAK -> no host ACK; res_code = 1. Repeat with STALL -> res_code = 2.
- IN with no response -> res_code = 3 exactly TIMEOUT_CYCLES+1 cycles after the token's tx_pkt_end.
- IN where the device returns DATA1 while cmd_toggle = 0 -> ACK sent, res_code = 5. Same with rx_crc_err = 1 -> no ACK, res_code = 4. cmd_len 2 with 3 bytes received -> res_code = 6, 2 in_valid strobes.
- rst asserted during DAT_BYTES -> all outputs at reset values the same cycle, no res_valid; the next command then completes normally.
